// File: rtl/eeprom_pkg.sv
// eeprom_pkg: shared types, widths and timing defaults for the EEPROM command sequencer.
package eeprom_pkg;
    localparam int EEPROM_ADDR_W = 11;
    localparam int EEPROM_DATA_W = 8;
    localparam int TWR_CYCLES_DEF = 250000;
    localparam int TIMEOUT_CYCLES_DEF = 4096;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_END, GAP, RESP} seq_state_t;
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = a > b ? a : b;
        return m < 2 ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/eeprom_cmd_seq_if.sv
// eeprom_cmd_seq_if: command/response handshake and controller strobes of the sequencer.
interface eeprom_cmd_seq_if;
    import eeprom_pkg::*;
    logic                     CMD_VALID;
    logic                     CMD_READY;
    logic                     CMD_WR;
    logic [EEPROM_ADDR_W-1:0] CMD_ADDR;
    logic [EEPROM_DATA_W-1:0] CMD_WDATA;
    logic                     RSP_VALID;
    logic [EEPROM_DATA_W-1:0] RSP_RDATA;
    logic                     RSP_ERR;
    logic                     RD;
    logic                     WR;
    logic [EEPROM_ADDR_W-1:0] ADDR;
    logic                     RD_END;
    logic                     WR_END;
    modport master (
        input  CMD_VALID, CMD_WR, CMD_ADDR, CMD_WDATA, RD_END, WR_END,
        output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RD, WR, ADDR
    );
    modport slave (
        output CMD_VALID, CMD_WR, CMD_ADDR, CMD_WDATA, RD_END, WR_END,
        input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR, RD, WR, ADDR
    );
endinterface

// File: rtl/eeprom_cmd_seq.sv
// eeprom_cmd_seq: serialises single-byte read/write commands onto the EEPROM controller,
// with end-of-op timeout and a post-write programming gap before the response.
module eeprom_cmd_seq
    import eeprom_pkg::*;
#(
    parameter int TWR_CYCLES     = TWR_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET,
    eeprom_cmd_seq_if.master         bus,
    inout  wire [EEPROM_DATA_W-1:0]  DATA
);
    localparam int CW = cnt_width(TWR_CYCLES, TIMEOUT_CYCLES);

    seq_state_t               state, state_n;
    logic [CW-1:0]            cnt, cnt_n;
    logic                     op_wr, op_wr_n;
    logic                     err, err_n;
    logic [EEPROM_ADDR_W-1:0] addr_q, addr_n;
    logic [EEPROM_DATA_W-1:0] wdata_q, wdata_n;
    logic [EEPROM_DATA_W-1:0] rdata_q, rdata_n;
    logic                     end_hit;
    logic                     tmo;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            op_wr   <= 1'b0;
            err     <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            op_wr   <= op_wr_n;
            err     <= err_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            rdata_q <= rdata_n;
        end
    end

    // END of the matching kind beats a timeout reached in the same cycle
    always_comb begin
        state_n = state;
        op_wr_n = op_wr;
        err_n   = err;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        rdata_n = rdata_q;
        end_hit = op_wr ? bus.WR_END : bus.RD_END;
        tmo     = cnt == CW'(TIMEOUT_CYCLES - 1);
        case (state)
            IDLE: if (bus.CMD_VALID) begin
                state_n = ISSUE;
                op_wr_n = bus.CMD_WR;
                addr_n  = bus.CMD_ADDR;
                wdata_n = bus.CMD_WDATA;
                err_n   = 1'b0;
            end
            ISSUE: state_n = cnt == CW'(1) ? WAIT_END : ISSUE;
            WAIT_END: if (end_hit || tmo) begin
                state_n = op_wr ? GAP : RESP;
                err_n   = !end_hit;
                rdata_n = op_wr ? rdata_q : (end_hit ? DATA : '0);
            end
            GAP: state_n = cnt == CW'(TWR_CYCLES - 1) ? RESP : GAP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        cnt_n = (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
    end

    assign bus.CMD_READY = state == IDLE;
    assign bus.RD        = state == ISSUE && !op_wr;
    assign bus.WR        = state == ISSUE && op_wr;
    assign bus.ADDR      = addr_q;
    assign bus.RSP_VALID = state == RESP;
    assign bus.RSP_ERR   = state == RESP && err;
    assign bus.RSP_RDATA = rdata_q;
    assign DATA = (op_wr && (state == ISSUE || state == WAIT_END)) ? wdata_q : 'z;
endmodule

// File: tb/tb_eeprom_cmd_seq.sv
// tb_eeprom_cmd_seq: directed checks of the EEPROM command sequencer against hand-derived timing.
module tb_eeprom_cmd_seq;
    import eeprom_pkg::*;
    localparam int TWR = 40;
    localparam int TMO = 512;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    eeprom_cmd_seq_if bus();
    wire [7:0] DATA;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_dout = 8'h00;
    assign DATA = tb_oe ? tb_dout : 8'hzz;

    eeprom_cmd_seq #(.TWR_CYCLES(TWR), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus),
        .DATA(DATA)
    );

    int n_checks = 0;
    int n_fail = 0;
    int overlap = 0;

    always @(negedge CLK) if (bus.RD && bus.WR) overlap++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic issue_cmd(input logic wr, input logic [10:0] a, input logic [7:0] d);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WR    = wr;
        bus.CMD_ADDR  = a;
        bus.CMD_WDATA = d;
        tick();
        bus.CMD_VALID = 1'b0;
    endtask

    // a latched byte is always nonzero when this is used, so 0 or unknown means released
    function automatic logic dut_drv();
        return !($isunknown(DATA) || DATA == 8'h00);
    endfunction

    initial begin
        int k;
        int bad;
        bus.CMD_VALID = 1'b0;
        bus.CMD_WR    = 1'b0;
        bus.CMD_ADDR  = '0;
        bus.CMD_WDATA = '0;
        bus.RD_END    = 1'b0;
        bus.WR_END    = 1'b0;
        tick(2);
        check("rst_ready", bus.CMD_READY, 1);
        check("rst_rd", bus.RD, 0);
        check("rst_wr", bus.WR, 0);
        check("rst_addr", bus.ADDR, 0);
        check("rst_rsp_valid", bus.RSP_VALID, 0);
        check("rst_rsp_err", bus.RSP_ERR, 0);
        check("rst_rdata", bus.RSP_RDATA, 0);
        RESET = 1'b1;
        tick();

        issue_cmd(1'b1, 11'h5A7, 8'h3C);
        check("wr_issue1", bus.WR, 1);
        check("wr_issue1_rd", bus.RD, 0);
        check("wr_addr", bus.ADDR, 11'h5A7);
        check("wr_data", DATA, 8'h3C);
        check("wr_ready_busy", bus.CMD_READY, 0);
        tick();
        check("wr_issue2", bus.WR, 1);
        tick();
        check("wr_wait_low", bus.WR, 0);
        bad = 0;
        repeat (298) begin
            if (DATA !== 8'h3C || bus.RSP_VALID) bad++;
            tick();
        end
        if (DATA !== 8'h3C) bad++;
        check("wr_data_held", bad, 0);
        bus.WR_END = 1'b1;
        tick();
        bus.WR_END = 1'b0;
        check("wr_data_release", dut_drv(), 0);
        k = 1;
        bad = 0;
        while (!bus.RSP_VALID && k < TWR + 10) begin
            if (bus.CMD_READY || dut_drv()) bad++;
            tick();
            k++;
        end
        check("wr_gap_len", k, TWR + 1);
        check("wr_gap_quiet", bad, 0);
        check("wr_rsp_err", bus.RSP_ERR, 0);
        tick();
        check("wr_ready_after", bus.CMD_READY, 1);
        check("wr_valid_drop", bus.RSP_VALID, 0);

        issue_cmd(1'b0, 11'h012, 8'hFF);
        check("rd_issue1", bus.RD, 1);
        check("rd_issue1_wr", bus.WR, 0);
        check("rd_addr", bus.ADDR, 11'h012);
        bad = int'(dut_drv());
        tick();
        check("rd_issue2", bus.RD, 1);
        bad += int'(dut_drv());
        tick();
        check("rd_wait_low", bus.RD, 0);
        bus.WR_END = 1'b1;
        tick();
        bus.WR_END = 1'b0;
        bad += int'(dut_drv());
        tick(3);
        bad += int'(dut_drv());
        check("rd_data_hiz", bad, 0);
        tb_oe = 1'b1;
        tb_dout = 8'hA5;
        bus.RD_END = 1'b1;
        tick();
        bus.RD_END = 1'b0;
        tb_oe = 1'b0;
        check("rd_rsp_valid", bus.RSP_VALID, 1);
        check("rd_rdata", bus.RSP_RDATA, 8'hA5);
        check("rd_rsp_err", bus.RSP_ERR, 0);
        tick();
        check("rd_valid_pulse", bus.RSP_VALID, 0);
        check("rd_rdata_hold", bus.RSP_RDATA, 8'hA5);

        issue_cmd(1'b0, 11'h7FF, 8'hFF);
        tick(2);
        k = 0;
        while (!bus.RSP_VALID && k < TMO + 10) begin
            tick();
            k++;
        end
        check("tmo_len", k, TMO);
        check("tmo_err", bus.RSP_ERR, 1);
        check("tmo_rdata", bus.RSP_RDATA, 8'h00);
        tick();

        issue_cmd(1'b0, 11'h400, 8'hFF);
        tick(2);
        tick(TMO - 1);
        check("edge_pending", bus.RSP_VALID, 0);
        tb_oe = 1'b1;
        tb_dout = 8'h5C;
        bus.RD_END = 1'b1;
        tick();
        bus.RD_END = 1'b0;
        tb_oe = 1'b0;
        check("edge_valid", bus.RSP_VALID, 1);
        check("edge_err", bus.RSP_ERR, 0);
        check("edge_rdata", bus.RSP_RDATA, 8'h5C);
        tick();

        issue_cmd(1'b1, 11'h123, 8'h81);
        tick(2);
        bus.WR_END = 1'b1;
        tick();
        bus.WR_END = 1'b0;
        tick(TWR / 2);
        check("gap_mid_hiz", dut_drv(), 0);
        check("gap_mid_ready", bus.CMD_READY, 0);
        RESET = 1'b0;
        tick();
        check("gaprst_ready", bus.CMD_READY, 1);
        check("gaprst_valid", bus.RSP_VALID, 0);
        check("gaprst_addr", bus.ADDR, 0);
        check("gaprst_rdata", bus.RSP_RDATA, 0);
        check("gaprst_hiz", $isunknown(DATA) || DATA == 8'h00, 1);
        RESET = 1'b1;
        bad = 0;
        repeat (TWR + 5) begin
            if (bus.RSP_VALID || !bus.CMD_READY) bad++;
            tick();
        end
        check("gaprst_no_rsp", bad, 0);

        issue_cmd(1'b1, 11'h2AA, 8'h55);
        bus.CMD_VALID = 1'b1;
        bus.CMD_WR    = 1'b0;
        bus.CMD_ADDR  = 11'h0F0;
        bus.CMD_WDATA = 8'h00;
        bad = 0;
        repeat (10) begin
            if (bus.CMD_READY) bad++;
            tick();
        end
        bus.WR_END = 1'b1;
        tick();
        bus.WR_END = 1'b0;
        k = 1;
        while (!bus.RSP_VALID && k < TWR + 10) begin
            if (bus.CMD_READY) bad++;
            tick();
            k++;
        end
        check("b2b_ready_low", bad, 0);
        check("b2b_gap_len", k, TWR + 1);
        check("b2b_resp_ready", bus.CMD_READY, 0);
        check("b2b_addr_hold", bus.ADDR, 11'h2AA);
        tick();
        check("b2b_ready_after", bus.CMD_READY, 1);
        tick();
        bus.CMD_VALID = 1'b0;
        check("b2b_rd", bus.RD, 1);
        check("b2b_addr_new", bus.ADDR, 11'h0F0);
        tick(2);
        tb_oe = 1'b1;
        tb_dout = 8'h3E;
        bus.RD_END = 1'b1;
        tick();
        bus.RD_END = 1'b0;
        tb_oe = 1'b0;
        check("b2b_rsp_valid", bus.RSP_VALID, 1);
        check("b2b_rdata", bus.RSP_RDATA, 8'h3E);
        tick();

        check("rd_wr_overlap", overlap, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/eeprom_cmd_seq.md
EEPROM_CMD_SEQ -- requirements
Module: eeprom_cmd_seq

Interface
REQ-001 Parameters: TWR_CYCLES, default 250000, write-cycle gap after WR_END (5 ms at 50 MHz).
REQ-002 Parameters: TIMEOUT_CYCLES, default 4096, maximum cycles from op start to RD_END/WR_END.
REQ-003 CLK  input  1  single clock. All logic runs on the rising edge.
REQ-004 RESET  input  1  synchronous active-low reset.
REQ-005 CMD_VALID  input  1  command offered. CMD_READY  output  1  sequencer can accept.
REQ-006 CMD_WR  input  1  1=write, 0=read. CMD_ADDR  input  11  byte address. CMD_WDATA  input  8  write byte.
REQ-007 RSP_VALID  output  1  one-cycle completion pulse. RSP_RDATA  output  8  read byte. RSP_ERR  output  1  timeout flag.
REQ-008 RD / WR  output  1 each  request strobes to the EEPROM controller.
REQ-009 ADDR  output  11  address to the controller. DATA  inout  8  shared data bus.
REQ-010 RD_END / WR_END  input  1 each  completion pulses from the controller.

Function
REQ-011 States: IDLE, ISSUE, WAIT_END, GAP, RESP.
REQ-012 CMD_READY is 1 only in IDLE. A transfer is CMD_VALID&CMD_READY on one edge. On transfer, CMD_WR, CMD_ADDR and CMD_WDATA are latched and the state goes to ISSUE.
REQ-013 ADDR and the latched write byte stay constant from ISSUE through WAIT_END. The controller samples them late in the operation.
REQ-014 ISSUE lasts exactly 2 cycles, which guarantees one high phase of the controller's divided SCL.
  - RD=1 in ISSUE when the op is a read; WR=1 in ISSUE when the op is a write.
  - RD and WR are never both 1.
  - Both are 0 in every other state.
REQ-015 DATA is driven with the latched write byte from ISSUE through WAIT_END of a write op. Otherwise DATA is high-Z.
REQ-016 WAIT_END counts cycles from entry.
  - Read: RD_END=1 captures DATA into RSP_RDATA, clears the error flag, goes to RESP.
  - Write: WR_END=1 clears the error flag and goes to GAP.
  - The END input of the other kind is ignored.
REQ-017 Timeout: if the counter reaches TIMEOUT_CYCLES-1 without the matching END, set the error flag. A read goes to RESP with RSP_RDATA=8'h00. A write goes to GAP.
REQ-018 If END arrives in the same cycle the timeout count is reached, END wins and the error flag stays 0.
REQ-019 GAP holds exactly TWR_CYCLES cycles, counting from 0 to TWR_CYCLES-1, then goes to RESP. The response to a write is issued only after the gap. No command is accepted during GAP.
REQ-020 RESP lasts one cycle: RSP_VALID=1, RSP_ERR=error flag, then IDLE. RSP_RDATA holds its value until the next read response.
REQ-021 A new command may be accepted on the cycle after RESP. Back-to-back throughput is therefore 1 + 2 + (END latency) + [TWR_CYCLES] + 1 cycles.
REQ-022 Counter width is clog2(max(TWR_CYCLES, TIMEOUT_CYCLES)). Counters clear on every state entry and never wrap.
REQ-023 CMD_VALID while not in IDLE has no effect. The command must be held by the source (valid/ready rule).

Reset
REQ-024 RESET=0 at an edge forces IDLE in every case, including mid-op and during GAP. After that edge:
  - CMD_READY=1.
  - RD=WR=0.
  - DATA high-Z.
  - ADDR=0.
  - RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0.
  - Counters=0.
REQ-025 The controller is reset by the same RESET net. No abort handshake is required.

Structure
REQ-026 Shared package eeprom_pkg holds:
  - the state enum;
  - EEPROM_ADDR_W=11 and EEPROM_DATA_W=8;
  - default TWR/TIMEOUT constants.
REQ-027 Flat module, no sub-module. The tri-state for DATA is a single continuous assignment.

Verification
REQ-028 Write 0x5A7 with data 0x3C, controller model pulses WR_END 300 cycles after WR. Required response:
  - WR high 2 cycles;
  - DATA=0x3C until WR_END;
  - RSP_VALID exactly TWR_CYCLES+1 cycles after WR_END;
  - RSP_ERR=0.
REQ-029 Read 0x012, model drives DATA=0xA5 with RD_END. Required response:
  - RD high 2 cycles;
  - DATA high-Z from the sequencer throughout;
  - RSP_RDATA=0xA5, RSP_ERR=0.
REQ-030 Read with no RD_END. Required response: RSP_VALID exactly TIMEOUT_CYCLES cycles after WAIT_END entry, with RSP_ERR=1 and RSP_RDATA=0x00.
REQ-031 RD_END on the final timeout cycle. Required response: RSP_ERR=0 with the captured data.
REQ-032 RESET=0 midway through GAP. Required response: next edge IDLE, CMD_READY=1, DATA high-Z, no RSP_VALID.
REQ-033 Command held during WAIT_END and GAP. Required response: CMD_READY=0 throughout, accepted on the cycle after RESP, and the bench model sees no overlapping RD/WR.
